// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding control for the 5-stage pipeline with a multi-cycle EX (MUL/DIV) hold.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_unit_mc #(
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] Rs1D,
  input  logic [RADDR_W-1:0] Rs2D,
  input  logic [RADDR_W-1:0] Rs1E,
  input  logic [RADDR_W-1:0] Rs2E,
  input  logic [RADDR_W-1:0] RdE,
  input  logic [RADDR_W-1:0] RdM,
  input  logic [RADDR_W-1:0] RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic               LuiM,
  input  logic [1:0]         ResultSrcE,
  input  logic [1:0]         PCSrcE,
  input  logic               MultiCycleE,
  output logic               StallF,
  output logic               StallD,
  output logic               StallE,
  output logic               FlushD,
  output logic               FlushE,
  output logic               FlushM,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               BusyE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt
`endif
);

  localparam int unsigned CntW = $clog2(MC_LATENCY);

  if (MC_LATENCY < 2 || MC_LATENCY > 64 || CNT_W < 1) begin : g_param_check
    $error("hazard_unit_mc: MC_LATENCY must be 2..64 and CNT_W at least 1");
  end

  typedef enum logic {StIdle, StWait} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              w_mcstall;
  logic              w_lwstall;
  logic              w_branch;

  // M has priority over W; x0 is never a forwarding source.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && (RdM != '0)) begin
      ForwardAE = LuiM ? 2'b11 : 2'b10;
    end else if (RegWriteW && (RdW == Rs1E) && (RdW != '0)) begin
      ForwardAE = 2'b01;
    end
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM == Rs2E) && (RdM != '0)) begin
      ForwardBE = LuiM ? 2'b11 : 2'b10;
    end else if (RegWriteW && (RdW == Rs2E) && (RdW != '0)) begin
      ForwardBE = 2'b01;
    end
  end

  assign w_lwstall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_branch  = (PCSrcE != 2'b00);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_mcstall = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (MultiCycleE) begin
          w_mcstall = 1'b1;
          w_cnt_d   = CntW'(MC_LATENCY - 2);
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (r_cnt != '0) begin
          w_mcstall = 1'b1;
          w_cnt_d   = r_cnt - 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // A taken branch cancels the load-use stall; the multi-cycle hold suppresses the load-use bubble.
  always_comb begin
    StallF = w_mcstall || (w_lwstall && !w_branch);
    StallD = StallF;
    StallE = w_mcstall;
    FlushM = w_mcstall;
    FlushD = w_branch;
    FlushE = w_branch || (w_lwstall && !w_mcstall);
    BusyE  = (r_state == StWait);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (MC_LATENCY=4, CNT_W=4).
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LuiM, MultiCycleE;
  logic [1:0] ResultSrcE, PCSrcE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] StallCnt, FlushCnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  hazard_unit_mc #(
    .RADDR_W   (5),
    .MC_LATENCY(4),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .LuiM       (LuiM),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MultiCycleE(MultiCycleE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .BusyE      (BusyE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LuiM = 1'b0; MultiCycleE = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 2'b00;
  endtask

  // Advance one clock and land 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs: {StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE}
  function automatic logic [31:0] ctl();
    return {25'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("reset_ctl", ctl(), 32'b0000000);
    chk("reset_fwd", {30'd0, ForwardAE}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_stallcnt", {28'd0, StallCnt}, 32'd0);
`endif
    #12;
    rst = 1'b0;
    tick();

    // Forwarding
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
    #1;
    chk("fwd_m_prio", {30'd0, ForwardAE}, 32'b10);
    chk("fwd_b_none", {30'd0, ForwardBE}, 32'b00);
    LuiM = 1'b1;
    #1;
    chk("fwd_lui", {30'd0, ForwardAE}, 32'b11);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_w", {30'd0, ForwardAE}, 32'b01);
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    #1;
    chk("fwd_x0", {30'd0, ForwardAE}, 32'b00);
    Rs2E = 5'd3; RdW = 5'd3;
    #1;
    chk("fwd_b_w", {30'd0, ForwardBE}, 32'b01);

    // Load-use
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lw_stall", ctl(), 32'b1100100);
    ResultSrcE = 2'b00;
    #1;
    chk("lw_not_load", ctl(), 32'b0000000);
    ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    chk("lw_x0", ctl(), 32'b0000000);

    // Taken branch overrides load-use
    RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 2'b01;
    #1;
    chk("br_over_lw", ctl(), 32'b0001100);
    clear_inputs();
    tick();

    // Multi-cycle op: hold cycles 0..3, then a back-to-back op in cycle 4
    MultiCycleE = 1'b1;
    #1;
    chk("mc_c0", ctl(), 32'b1110010);
    tick();
    chk("mc_c1", ctl(), 32'b1110011);
    tick();
    chk("mc_c2", ctl(), 32'b1110011);
    tick();
    chk("mc_c3", ctl(), 32'b0000001);
    tick();
    chk("mc_b2b_c0", ctl(), 32'b1110010);
    tick();
    MultiCycleE = 1'b0;
    #1;
    chk("mc_wait_ignores_in", ctl(), 32'b1110011);

    // Async reset in WAIT
    rst = 1'b1;
    #1;
    chk("mc_rst", ctl(), 32'b0000000);
    #1;
    rst = 1'b0;
    tick();
    chk("mc_after_rst", ctl(), 32'b0000000);

`ifdef HAZARD_PERF_CNT_EN
    chk("cnt_zero", {24'd0, FlushCnt, StallCnt}, 32'd0);
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    for (int i = 0; i < 10; i++) tick();
    chk("stallcnt_10", {28'd0, StallCnt}, 32'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("stallcnt_sat", {28'd0, StallCnt}, 32'd15);
    PCSrcE = 2'b10;
    for (int i = 0; i < 3; i++) tick();
    chk("flushcnt_3", {28'd0, FlushCnt}, 32'd3);
    chk("stallcnt_hold", {28'd0, StallCnt}, 32'd15);
    clear_inputs();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
